multicycle_sequencer: RTL and testbench

- Parametrised multicycle control sequencer that drives the IF/EX/WB datapath write enables and mux selects, one stage per state.
- Adds behaviour the fixed-timing top level lacks: ready handshakes with instruction and data memories, a bounded wait timeout with an error state, branch resolution from the condition-test result, HALT, and performance counters.
- Sits beside the datapath stages inside the processor top; a separate decoder supplies the instruction class.

---
 rtl/proc_pkg.sv | 29 ++
 rtl/sat_counter.sv | 22 ++
 rtl/multicycle_sequencer.sv | 161 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle control sequencer: FSM states,
// instruction class codes and datapath mux select values.
package proc_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    // Codes 6 and 7 both decode as NOP.
    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_JUMP   = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_HALT   = 3'd5;

    localparam logic MXPC_INC    = 1'b0;
    localparam logic MXPC_TARGET = 1'b1;
    localparam logic MXRB_ALU    = 1'b0;
    localparam logic MXRB_MEM    = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST)
            cnt_q <= '0;
        else if (inc && (cnt_q != {W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign q = cnt_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM: one datapath stage per state, memory ready
// handshakes with a bounded wait, branch resolution, HALT and perf counters.
module multicycle_sequencer
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       instr_class,
    input  logic             tf_out,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             W_IR,
    output logic             W_PC,
    output logic             S_MXPC,
    output logic             WE,
    output logic             WFLAGS,
    output logic             rf_WRF,
    output logic             S_MXRB,
    output logic [2:0]       stage,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] class_q, class_d;
    logic [7:0] wait_q, wait_d;

    logic w_ir, w_pc, mxpc, we, wflags, wrf, mxrb;
    logic cyc_inc;
    logic [CNT_W-1:0] cyc_cnt, ins_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            class_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        wait_d  = wait_q;
        w_ir    = 1'b0;
        w_pc    = 1'b0;
        mxpc    = MXPC_INC;
        we      = 1'b0;
        wflags  = 1'b0;
        wrf     = 1'b0;
        mxrb    = MXRB_ALU;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                // Ready wins over timeout when both land on the same cycle.
                if (imem_ready) begin
                    w_ir    = 1'b1;
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                class_d = instr_class;
                state_d = (instr_class == CLS_HALT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (class_q)
                    CLS_ALU: begin
                        wflags  = 1'b1;
                        state_d = S_WRITEBACK;
                    end
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    CLS_JUMP: begin
                        w_pc    = 1'b1;
                        mxpc    = MXPC_TARGET;
                        state_d = S_FETCH;
                    end
                    CLS_BRANCH: begin
                        w_pc    = 1'b1;
                        mxpc    = tf_out;
                        state_d = S_FETCH;
                    end
                    default: begin
                        w_pc    = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                we = (class_q == CLS_STORE);
                if (dmem_ready) begin
                    wait_d = '0;
                    if (class_q == CLS_STORE) begin
                        w_pc    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) state_d = S_ERROR;
                end
            end
            S_WRITEBACK: begin
                wrf     = 1'b1;
                mxrb    = (class_q == CLS_LOAD) ? MXRB_MEM : MXRB_ALU;
                w_pc    = 1'b1;
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    // Reset masks every output so a mid-instruction reset never half-writes.
    assign W_IR        = w_ir   & ~RST;
    assign W_PC        = w_pc   & ~RST;
    assign S_MXPC      = mxpc   & ~RST;
    assign WE          = we     & ~RST;
    assign WFLAGS      = wflags & ~RST;
    assign rf_WRF      = wrf    & ~RST;
    assign S_MXRB      = mxrb   & ~RST;
    assign stage       = RST ? 3'd0 : state_q;
    assign halted      = ~RST & (state_q == S_HALT);
    assign err_timeout = ~RST & (state_q == S_ERROR);

    assign cyc_inc = ~RST & (state_q != S_IDLE) & (state_q != S_HALT) & (state_q != S_ERROR);

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (cyc_inc),
        .q   (cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ins_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (W_PC),
        .q   (ins_cnt)
    );

    assign cycle_count = RST ? '0 : cyc_cnt;
    assign instr_count = RST ? '0 : ins_cnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed and randomized instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_sequencer;

    localparam int CW = 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EX = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;
    localparam logic [2:0] ALU = 3'd0, LOAD = 3'd1, STORE = 3'd2, JUMP = 3'd3,
                           BRANCH = 3'd4, HALT = 3'd5;
    // Control vector order: W_IR W_PC S_MXPC WE WFLAGS rf_WRF S_MXRB
    localparam logic [6:0] C_WIR = 7'b1000000, C_WPC = 7'b0100000, C_MXPC = 7'b0010000,
                           C_WE = 7'b0001000, C_WFL = 7'b0000100, C_RF = 7'b0000010,
                           C_MXRB = 7'b0000001;

    logic CLK = 1'b0;
    logic RST = 1'b1, start = 1'b0, tf_out = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [2:0] instr_class = 3'd0;
    logic W_IR, W_PC, S_MXPC, WE, WFLAGS, rf_WRF, S_MXRB, halted, err_timeout;
    logic [2:0] stage;
    logic [CW-1:0] cycle_count, instr_count;

    logic RST2 = 1'b1, start2 = 1'b0;
    logic W_IR2, W_PC2, S_MXPC2, WE2, WFLAGS2, rf_WRF2, S_MXRB2, halted2, err2;
    logic [2:0] stage2;
    logic [CW-1:0] cyc2, ins2;

    int checks = 0, errors = 0;
    logic [CW-1:0] m_cyc = '0, m_ins = '0;

    always #5 CLK = ~CLK;

    multicycle_sequencer #(.TIMEOUT(16), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .instr_class(instr_class), .tf_out(tf_out),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .W_IR(W_IR), .W_PC(W_PC),
        .S_MXPC(S_MXPC), .WE(WE), .WFLAGS(WFLAGS), .rf_WRF(rf_WRF), .S_MXRB(S_MXRB),
        .stage(stage), .halted(halted), .err_timeout(err_timeout),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    multicycle_sequencer #(.TIMEOUT(4), .CNT_W(CW)) dut_to (
        .CLK(CLK), .RST(RST2), .start(start2), .instr_class(instr_class), .tf_out(tf_out),
        .imem_ready(1'b0), .dmem_ready(dmem_ready), .W_IR(W_IR2), .W_PC(W_PC2),
        .S_MXPC(S_MXPC2), .WE(WE2), .WFLAGS(WFLAGS2), .rf_WRF(rf_WRF2), .S_MXRB(S_MXRB2),
        .stage(stage2), .halted(halted2), .err_timeout(err2),
        .cycle_count(cyc2), .instr_count(ins2)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rc();
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input logic rst, input logic st, input logic [2:0] cls, input logic tf,
                       input logic ir, input logic dr, input logic [2:0] es,
                       input logic [6:0] ec, input string tag);
        @(negedge CLK);
        RST = rst; start = st; instr_class = cls; tf_out = tf;
        imem_ready = ir; dmem_ready = dr;
        #1;
        chk({tag, ":stage"}, 32'(stage), 32'(es));
        chk({tag, ":ctl"}, 32'({W_IR, W_PC, S_MXPC, WE, WFLAGS, rf_WRF, S_MXRB}), 32'(ec));
        chk({tag, ":halted"}, 32'(halted), 32'(es == S_HALT && !rst));
        chk({tag, ":err"}, 32'(err_timeout), 32'(es == S_ERR && !rst));
        chk({tag, ":cycles"}, 32'(cycle_count), rst ? 32'd0 : 32'(m_cyc));
        chk({tag, ":instrs"}, 32'(instr_count), rst ? 32'd0 : 32'(m_ins));
        if (rst) begin
            m_cyc = '0; m_ins = '0;
        end else begin
            if (es != S_IDLE && es != S_HALT && es != S_ERR && m_cyc != '1) m_cyc++;
            if (ec[5] && m_ins != '1) m_ins++;
        end
    endtask

    // Whole instruction from FETCH to retire, with iw/dw not-ready wait cycles.
    task automatic run_instr(input logic [2:0] cls, input logic tf, input int iw, input int dw);
        logic [6:0] mw, mr;
        for (int i = 0; i < iw; i++) cyc(0, rb(), rc(), rb(), 0, rb(), S_FETCH, 0, "fetch_wait");
        cyc(0, rb(), rc(), rb(), 1, rb(), S_FETCH, C_WIR, "fetch");
        cyc(0, rb(), cls, rb(), rb(), rb(), S_DEC, 0, "decode");
        case (cls)
            HALT: ;
            ALU: begin
                cyc(0, rb(), rc(), rb(), rb(), rb(), S_EX, C_WFL, "ex_alu");
                cyc(0, rb(), rc(), rb(), rb(), rb(), S_WB, C_RF | C_WPC, "wb_alu");
            end
            LOAD, STORE: begin
                mw = (cls == STORE) ? C_WE : 7'd0;
                mr = (cls == STORE) ? (C_WE | C_WPC) : 7'd0;
                cyc(0, rb(), rc(), rb(), rb(), rb(), S_EX, 0, "ex_mem");
                for (int i = 0; i < dw; i++) cyc(0, rb(), rc(), rb(), rb(), 0, S_MEM, mw, "mem_wait");
                cyc(0, rb(), rc(), rb(), rb(), 1, S_MEM, mr, "mem_done");
                if (cls == LOAD) cyc(0, rb(), rc(), rb(), rb(), rb(), S_WB, C_RF | C_MXRB | C_WPC, "wb_load");
            end
            JUMP:   cyc(0, rb(), rc(), rb(), rb(), rb(), S_EX, C_WPC | C_MXPC, "ex_jump");
            BRANCH: cyc(0, rb(), rc(), tf, rb(), rb(), S_EX, tf ? (C_WPC | C_MXPC) : C_WPC, "ex_branch");
            default: cyc(0, rb(), rc(), rb(), rb(), rb(), S_EX, C_WPC, "ex_nop");
        endcase
    endtask

    initial begin
        logic [2:0] c;
        // Reset and idle
        for (int i = 0; i < 3; i++) cyc(1, rb(), rc(), rb(), rb(), rb(), S_IDLE, 0, "reset");
        for (int i = 0; i < 4; i++) cyc(0, 0, rc(), rb(), rb(), rb(), S_IDLE, 0, "idle");
        cyc(0, 1, rc(), rb(), rb(), rb(), S_IDLE, 0, "start");

        // Directed instructions, including waits landing on the last allowed cycle
        run_instr(ALU, 0, 0, 0);
        run_instr(BRANCH, 1, 0, 0);
        run_instr(BRANCH, 0, 0, 0);
        run_instr(STORE, 0, 0, 5);
        run_instr(LOAD, 0, 2, 3);
        run_instr(JUMP, 0, 0, 0);
        run_instr(3'd6, 0, 0, 0);
        run_instr(3'd7, 0, 1, 0);
        run_instr(STORE, 0, 15, 15);
        run_instr(LOAD, 0, 0, 15);

        // Random stream, long enough to saturate both 8-bit counters
        for (int n = 0; n < 300; n++) begin
            c = rc();
            if (c == HALT) c = JUMP;
            run_instr(c, rb(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end

        // HALT absorbs, start ignored
        run_instr(HALT, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, rb(), rc(), rb(), rb(), rb(), S_HALT, 0, "halt");
        cyc(1, rb(), rc(), rb(), rb(), rb(), S_IDLE, 0, "reset_halt");

        // Reset in the middle of a STORE's MEM wait
        cyc(0, 1, rc(), rb(), rb(), rb(), S_IDLE, 0, "start2");
        cyc(0, rb(), rc(), rb(), 1, rb(), S_FETCH, C_WIR, "fetch");
        cyc(0, rb(), STORE, rb(), rb(), rb(), S_DEC, 0, "decode");
        cyc(0, rb(), rc(), rb(), rb(), rb(), S_EX, 0, "ex_mem");
        cyc(0, rb(), rc(), rb(), rb(), 0, S_MEM, C_WE, "mem_wait");
        cyc(1, rb(), rc(), rb(), rb(), 1, S_IDLE, 0, "reset_mem");
        cyc(0, 0, rc(), rb(), rb(), rb(), S_IDLE, 0, "idle_after");

        // MEM timeout: 16 not-ready cycles then ERROR, absorbing
        cyc(0, 1, rc(), rb(), rb(), rb(), S_IDLE, 0, "start3");
        cyc(0, rb(), rc(), rb(), 1, rb(), S_FETCH, C_WIR, "fetch");
        cyc(0, rb(), STORE, rb(), rb(), rb(), S_DEC, 0, "decode");
        cyc(0, rb(), rc(), rb(), rb(), rb(), S_EX, 0, "ex_mem");
        for (int i = 0; i < 16; i++) cyc(0, rb(), rc(), rb(), rb(), 0, S_MEM, C_WE, "mem_to");
        for (int i = 0; i < 4; i++) cyc(0, rb(), rc(), rb(), rb(), rb(), S_ERR, 0, "error");
        cyc(1, rb(), rc(), rb(), rb(), rb(), S_IDLE, 0, "reset_err");
        cyc(0, 0, rc(), rb(), rb(), rb(), S_IDLE, 0, "idle_end");

        // FETCH timeout with TIMEOUT=4
        @(negedge CLK); RST2 = 0; start2 = 1; #1;
        chk("to_idle", 32'(stage2), 32'(S_IDLE));
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); start2 = rb(); #1;
            chk("to_fetch", 32'(stage2), 32'(S_FETCH));
            chk("to_fetch_ctl", 32'({W_IR2, W_PC2, S_MXPC2, WE2, WFLAGS2, rf_WRF2, S_MXRB2}), 0);
            chk("to_fetch_cyc", 32'(cyc2), 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); start2 = rb(); #1;
            chk("to_err", 32'(stage2), 32'(S_ERR));
            chk("to_err_flag", 32'({err2, halted2}), 32'b10);
            chk("to_err_cnt", 32'({cyc2, ins2}), 32'({8'd4, 8'd0}));
        end
        @(negedge CLK); RST2 = 1; #1;
        chk("to_rst", 32'({stage2, err2}), 0);
        @(negedge CLK); RST2 = 0; start2 = 0; #1;
        chk("to_rst_idle", 32'({stage2, err2, cyc2}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
